// File: rtl/mul_pkg.sv
// Shared types for the radix-16 Booth multiplier datapath and its sequencer.
package mul_pkg;

  // Encoding equals the partial-product magnitude, so PP_kA has value k.
  typedef enum logic [3:0] {
    PP_0  = 4'd0,
    PP_A  = 4'd1,
    PP_2A = 4'd2,
    PP_3A = 4'd3,
    PP_4A = 4'd4,
    PP_5A = 4'd5,
    PP_6A = 4'd6,
    PP_7A = 4'd7,
    PP_8A = 4'd8
  } booth_sel_t;

endpackage

// File: rtl/booth_mul_seq_if.sv
// Request, digit-issue and completion signals between the Booth sequencer and its user.
interface booth_mul_seq_if #(
  parameter int unsigned WIDTH        = 52,
  parameter int unsigned COUNTERWIDTH = 4
);
  logic                    in_valid_i;
  logic                    in_ready_o;
  logic [WIDTH-1:0]        op_b_i;
  logic                    kill_i;
  logic                    step_valid_o;
  mul_pkg::booth_sel_t     sel_o;
  logic                    neg_o;
  logic [COUNTERWIDTH-1:0] step_idx_o;
  logic                    first_o;
  logic                    last_o;
  logic                    busy_o;
  logic                    out_valid_o;
  logic                    out_ready_i;

  modport master (
    output in_valid_i, op_b_i, kill_i, out_ready_i,
    input  in_ready_o, step_valid_o, sel_o, neg_o, step_idx_o,
           first_o, last_o, busy_o, out_valid_o
  );

  modport slave (
    input  in_valid_i, op_b_i, kill_i, out_ready_i,
    output in_ready_o, step_valid_o, sel_o, neg_o, step_idx_o,
           first_o, last_o, busy_o, out_valid_o
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Radix-16 Booth digit sequencer: latches the multiplier and issues one signed
// digit per cycle to the datapath, then holds completion until accepted.
module booth_mul_seq #(
  parameter int unsigned WIDTH        = 52,
  parameter int unsigned MULCYCLES    = WIDTH / 4,
  parameter int unsigned COUNTERWIDTH = $clog2(MULCYCLES)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  booth_mul_seq_if.slave bus
);
  import mul_pkg::*;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [COUNTERWIDTH-1:0] LAST_IDX = COUNTERWIDTH'(MULCYCLES - 1);

  state_t                  state_q, state_d;
  logic [WIDTH:0]          sr_q, sr_d;
  logic [COUNTERWIDTH-1:0] cnt_q, cnt_d;
  logic signed [4:0]       digit;
  logic [3:0]              mag;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid_i && !bus.kill_i) begin
          sr_d    = {bus.op_b_i, 1'b0};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sr_d = {{4{sr_q[WIDTH]}}, sr_q[WIDTH:4]};
        if (cnt_q == LAST_IDX) state_d = DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      DONE: begin
        if (bus.out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.kill_i && state_q != IDLE) state_d = IDLE;
  end

  // Window b3 b2 b1 b0 b-1: the signed nibble b3..b0 plus the borrowed b-1.
  always_comb begin
    digit = $signed({sr_q[4], sr_q[4:1]}) + $signed({4'b0000, sr_q[0]});
    mag   = digit[4] ? 4'(-digit) : digit[3:0];
  end

  always_comb begin
    bus.in_ready_o   = (state_q == IDLE);
    bus.busy_o       = (state_q != IDLE);
    bus.out_valid_o  = (state_q == DONE);
    bus.step_valid_o = (state_q == RUN);
    bus.sel_o        = PP_0;
    bus.neg_o        = 1'b0;
    bus.step_idx_o   = '0;
    bus.first_o      = 1'b0;
    bus.last_o       = 1'b0;
    if (state_q == RUN) begin
      bus.sel_o      = booth_sel_t'(mag);
      bus.neg_o      = digit[4];
      bus.step_idx_o = cnt_q;
      bus.first_o    = (cnt_q == '0);
      bus.last_o     = (cnt_q == LAST_IDX);
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: directed operands with hand-worked digits,
// product reconstruction from issued digits, kill/reset aborts and backpressure.
module tb_booth_mul_seq;
  import mul_pkg::*;

  localparam int unsigned WIDTH = 52;
  localparam int unsigned MUL   = 13;
  localparam int unsigned CW    = 4;

  typedef struct {
    int          sel;
    bit          neg;
    int          idx;
    bit          first;
    bit          last;
    int unsigned cyc;
    bit          chk;
  } step_t;

  typedef struct {
    longint      val;
    int unsigned cyc;
  } res_t;

  logic clk;
  logic rst;
  int unsigned cyc;
  int checks;
  int failures;
  bit mon_en;

  step_t step_q[$];
  res_t  res_q[$];
  int    es[MUL];
  bit    en[MUL];

  booth_mul_seq_if #(.WIDTH(WIDTH), .COUNTERWIDTH(CW)) bus ();

  booth_mul_seq #(.WIDTH(WIDTH), .MULCYCLES(MUL), .COUNTERWIDTH(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  step_t  me;
  res_t   mr;
  longint acc;
  bit     ov_prev;
  bit     act;
  int     d;

  initial begin
    acc     = 0;
    ov_prev = 0;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      act = bus.step_valid_o || bus.out_valid_o;
      chk("in_ready_vs_activity", longint'(bus.in_ready_o), longint'(!act));
      chk("busy_vs_activity", longint'(bus.busy_o), longint'(act));
      if (bus.step_valid_o) begin
        if (step_q.size() == 0) begin
          chk("unexpected_step", 1, 0);
        end else begin
          me = step_q.pop_front();
          chk("step_idx", longint'(bus.step_idx_o), me.idx);
          chk("step_cycle", cyc, me.cyc);
          chk("first", longint'(bus.first_o), longint'(me.first));
          chk("last", longint'(bus.last_o), longint'(me.last));
          if (me.chk) begin
            chk("sel", longint'(int'(bus.sel_o)), me.sel);
            chk("neg", longint'(bus.neg_o), longint'(me.neg));
          end
          if (me.idx == 0) acc = 0;
          d = bus.neg_o ? -int'(bus.sel_o) : int'(bus.sel_o);
          acc = acc + (longint'(d) <<< (4 * me.idx));
        end
      end else begin
        chk("idle_digit_outputs",
            {int'(bus.sel_o), 28'(0)} | {bus.neg_o, bus.first_o, bus.last_o} | longint'(bus.step_idx_o) << 3,
            0);
      end
      if (bus.out_valid_o && !ov_prev) begin
        if (res_q.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          mr = res_q.pop_front();
          chk("done_cycle", cyc, mr.cyc);
          chk("product_sum", acc, mr.val);
        end
      end
      ov_prev = bus.out_valid_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    for (int i = 0; i < int'(MUL); i++) begin
      es[i] = 0;
      en[i] = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (bus.in_ready_o !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (t >= 60) chk("timeout_in_ready", 0, 1);
  endtask

  // Drives one request; stop_at < 0 means it runs to completion, otherwise the
  // caller aborts it while step stop_at is on the outputs.
  task automatic issue(input logic [WIDTH-1:0] b, input bit hand, input int stop_at);
    int n;
    int unsigned a;
    step_t s;
    res_t  r;
    wait_ready();
    a = cyc + 1;
    n = (stop_at < 0) ? int'(MUL) : stop_at + 1;
    for (int i = 0; i < n; i++) begin
      s.sel   = es[i];
      s.neg   = en[i];
      s.idx   = i;
      s.first = (i == 0);
      s.last  = (i == int'(MUL) - 1);
      s.cyc   = a + i;
      s.chk   = hand;
      step_q.push_back(s);
    end
    if (stop_at < 0) begin
      r.val = longint'($signed(b));
      r.cyc = a + MUL;
      res_q.push_back(r);
    end
    bus.in_valid_i = 1'b1;
    bus.op_b_i     = b;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  initial begin
    int t;
    logic [WIDTH-1:0] ones;
    mon_en          = 1'b0;
    checks          = 0;
    failures        = 0;
    ones            = '1;
    rst             = 1'b1;
    bus.in_valid_i  = 1'b0;
    bus.op_b_i      = '0;
    bus.kill_i      = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready", longint'(bus.in_ready_o), 1);
    chk("rst_busy", longint'(bus.busy_o), 0);
    chk("rst_step_valid", longint'(bus.step_valid_o), 0);
    chk("rst_sel", longint'(int'(bus.sel_o)), 0);
    chk("rst_neg", longint'(bus.neg_o), 0);
    chk("rst_step_idx", longint'(bus.step_idx_o), 0);
    chk("rst_first", longint'(bus.first_o), 0);
    chk("rst_last", longint'(bus.last_o), 0);
    chk("rst_out_valid", longint'(bus.out_valid_o), 0);
    mon_en = 1'b1;

    clr(); es[0] = 1;                          issue(52'h1, 1'b1, -1);
    clr(); es[0] = 1; en[0] = 1'b1;            issue(ones, 1'b1, -1);
    clr(); es[0] = 8; en[0] = 1'b1; es[1] = 1; issue(52'h8, 1'b1, -1);
    clr(); es[0] = 7;                          issue(52'h7, 1'b1, -1);
    clr(); es[0] = 4; en[0] = 1'b1; es[1] = 4; issue(52'h3C, 1'b1, -1);
    clr(); es[12] = 8; en[12] = 1'b1;          issue(52'h8000000000000, 1'b1, -1);
    clr();                                     issue(52'h0, 1'b1, -1);
    clr();                                     issue(52'h123456789ABCD, 1'b0, -1);
    clr();                                     issue(52'hFEDCBA9876543, 1'b0, -1);

    // Kill while idle must swallow a simultaneous request.
    wait_ready();
    bus.in_valid_i = 1'b1;
    bus.op_b_i     = 52'h5;
    bus.kill_i     = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.kill_i     = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_kill_no_accept", longint'(bus.in_ready_o), 1);

    // Kill during step 5.
    clr(); es[0] = 2;
    issue(52'h2, 1'b1, 5);
    repeat (5) @(negedge clk);
    bus.kill_i = 1'b1;
    @(negedge clk);
    bus.kill_i = 1'b0;
    chk("kill_in_ready", longint'(bus.in_ready_o), 1);
    chk("kill_step_valid", longint'(bus.step_valid_o), 0);
    repeat (16) @(negedge clk);
    clr(); es[0] = 1; issue(52'h1, 1'b1, -1);

    // Reset during step 9.
    clr(); es[0] = 1; en[0] = 1'b1;
    issue(ones, 1'b1, 9);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", longint'(bus.in_ready_o), 1);
    chk("midrst_out_valid", longint'(bus.out_valid_o), 0);
    repeat (16) @(negedge clk);
    clr(); es[0] = 7; issue(52'h7, 1'b1, -1);

    // Backpressure: completion held, requests ignored while done.
    wait_ready();
    bus.out_ready_i = 1'b0;
    clr(); es[0] = 1;
    issue(52'h1, 1'b1, -1);
    t = 0;
    while (bus.out_valid_o !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("timeout_out_valid", 0, 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid_held", longint'(bus.out_valid_o), 1);
      chk("bp_in_ready_low", longint'(bus.in_ready_o), 0);
      bus.in_valid_i = 1'b1;
      bus.op_b_i     = 52'h3;
      @(negedge clk);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", longint'(bus.in_ready_o), 1);
    chk("bp_release_out_valid", longint'(bus.out_valid_o), 0);

    t = 0;
    while (res_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("steps_outstanding", step_q.size(), 0);
    chk("results_outstanding", res_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Sequencer for the iterative radix-16 Booth multiplier datapath. It accepts a multiplication request through a valid/ready handshake and latches the multiplier operand. It then issues one Booth digit per cycle for `MULCYCLES` cycles, as a `mul_pkg::booth_sel_t` magnitude plus a negate flag. It holds the completion flag until the consumer accepts it. The block does no arithmetic on the multiplicand or product; the datapath owns the partial-product mux, accumulator and result.

## Interface
- `WIDTH`, 52: multiplier operand width. Must be a multiple of 4; two's complement.
- `MULCYCLES`, `WIDTH/4` (13): number of Booth digits/steps.
- `COUNTERWIDTH`, `$clog2(MULCYCLES)` (4): step counter width.

Ports:
- `clk_i` in 1: single clock; all state on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `in_valid_i` in 1: request valid.
- `in_ready_o` out 1: controller idle and able to accept.
- `op_b_i` in WIDTH: multiplier operand; sampled only on accept.
- `kill_i` in 1: synchronous abort of the in-flight operation.
- `step_valid_o` out 1: a digit is issued this cycle.
- `sel_o` out `mul_pkg::booth_sel_t`: partial-product magnitude, PP_0..PP_8A.
- `neg_o` out 1: subtract the selected partial product.
- `step_idx_o` out COUNTERWIDTH: index of the current digit, 0 = least significant.
- `first_o` out 1: first step; the datapath clears its accumulator.
- `last_o` out 1: final step.
- `busy_o` out 1: state is RUN or DONE.
- `out_valid_o` out 1: product in the datapath is complete.
- `out_ready_i` in 1: consumer accepts the result.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `in_ready_o`=1. On `in_valid_i`, load shift register `sr` ← {`op_b_i`, 1'b0} (WIDTH+1 bits), set counter to 0, and go to RUN.
  - RUN: each cycle, `step_valid_o`=1 and the digit is decoded from `sr[4:0]`. Then `sr` ← `sr` >>> 4 (arithmetic shift) and the counter increments. When counter==MULCYCLES-1, go to DONE.
  - DONE: `out_valid_o`=1. When `out_ready_i`=1, go to IDLE.
- Digit decode from window w = `sr[4:0]` (b3 b2 b1 b0 b−1):
  - d = −8·b3 + 4·b2 + 2·b1 + b0 + b−1, range −8..+8.
  - `sel_o` = PP_|d|; `neg_o` = (d<0).
  - d=0 gives PP_0 with `neg_o`=0, including windows 11111 and 00000.
- Step flags: `step_idx_o` = counter; `first_o` = RUN && counter==0; `last_o` = RUN && counter==MULCYCLES-1.
- When `step_valid_o`=0, the digit outputs are forced to `sel_o`=PP_0, `neg_o`=0, `step_idx_o`=0, `first_o`=`last_o`=0.
- `kill_i`:
  - In RUN or DONE: go to IDLE next cycle; `out_valid_o` is never raised for the killed operation.
  - In IDLE: ignored, and an accept in the same cycle is suppressed.
- Priority: `rst_i` > `kill_i` > normal transitions.
- Counter never exceeds MULCYCLES-1 and does not wrap.

## Timing
- Reset values, the cycle after `rst_i` is sampled high:
  - state=IDLE, `in_ready_o`=1, `busy_o`=0.
  - `step_valid_o`=0, `sel_o`=PP_0, `neg_o`=0, `step_idx_o`=0, `first_o`=0, `last_o`=0.
  - `out_valid_o`=0.
- `rst_i` mid-operation aborts identically to kill, with no completion.
- Accept in cycle T → steps issued in cycles T+1..T+MULCYCLES (T+1..T+13) → `out_valid_o` from T+MULCYCLES+1.
- `out_valid_o` is held, with no change, until `out_ready_i`. The handshake cycle is the last DONE cycle; `in_ready_o`=1 in the following cycle.
- Peak throughput is one operation per MULCYCLES+2 cycles (15).
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid_i` or `out_ready_i` to any output.

## Test plan
- After reset, accept `op_b`=1 → step 0: PP_A, neg=0, `first_o`=1; steps 1..12: PP_0, neg=0; `last_o` at step 12; `out_valid_o` exactly 14 cycles after accept.
- `op_b`=all-ones (−1) → step 0: PP_A, neg=1; steps 1..12: PP_0, neg=0.
- `op_b`=0x8 → step 0: PP_8A, neg=1; step 1: PP_A, neg=0; rest PP_0. `op_b`=0x7 → step 0: PP_7A, neg=0.
- Random 52-bit `op_b` (1000 iterations) → Σ d_i·16^i equals signed `op_b`, and `in_ready_o`=0 throughout RUN/DONE.
- Backpressure: hold `out_ready_i`=0 for 5 cycles after `out_valid_o` → `out_valid_o` stays 1 and a `in_valid_i` pulse is not accepted; release → IDLE next cycle.
- `kill_i` at step 5, and separately `rst_i` at step 9 → IDLE next cycle, no `out_valid_o`; the next accepted operation restarts at step 0 with `first_o`=1.
